clkgen_multi: RTL and testbench

Synthesizable multi-channel programmable clock/PWM generator. Replaces bench-only fixed-frequency, fixed-duty clock sources.
- Each channel derives a divided output from the system clock.
- Period and high time are set per channel, in clk cycles.
- Reconfiguration is glitch-free and takes effect at the period boundary.
- Drives test-clock and strobe consumers inside the design.

---
 rtl/clkgen_pkg.sv | 30 +++
 rtl/clkgen_channel.sv | 98 +++++++++
 rtl/clkgen_multi.sv | 58 +++++
 tb/tb_clkgen_multi.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clkgen_pkg.sv
// Shared types for the multi-channel clock/PWM generator.
// CLKGEN_PHASE_EN adds a per-channel start phase to the channel configuration.
package clkgen_pkg;

  localparam int CNT_W = 16;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    cnt_t period;
    cnt_t high;
`ifdef CLKGEN_PHASE_EN
    cnt_t phase;
`endif
  } ch_cfg_t;

`ifdef CLKGEN_PHASE_EN
  // Start count on enable: phase clamped into the period, 0 when idle.
  function automatic cnt_t start_cnt(input ch_cfg_t cfg);
    if (cfg.period == '0) begin
      return '0;
    end
    if (cfg.phase >= cfg.period - cnt_t'(1)) begin
      return cfg.period - cnt_t'(1);
    end
    return cfg.phase;
  endfunction
`endif

endpackage

// File: rtl/clkgen_channel.sv
// One generator channel: period counter, staged/active config, registered compare and tick.
// CLKGEN_PHASE_EN adds wr_phase_i and a phase-offset start count.
module clkgen_channel
  import clkgen_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable_i,
  input  logic             wr_en_i,
  input  logic [CNT_W-1:0] wr_period_i,
  input  logic [CNT_W-1:0] wr_high_i,
`ifdef CLKGEN_PHASE_EN
  input  logic [CNT_W-1:0] wr_phase_i,
`endif
  output logic             pending_o,
  output logic             clk_out_o,
  output logic             period_tick_o
);

  ch_cfg_t sh_q, sh_d;
  ch_cfg_t st_q, st_d;
  ch_cfg_t wr_cfg;
  cnt_t    cnt_q, cnt_d;
  logic    pend_q, pend_d;
  logic    en_q;
  logic    clk_q, clk_d;
  logic    tick_q, tick_d;
  logic    run_q, at_wrap, apply;

  always_comb begin
    wr_cfg.period = wr_period_i;
    wr_cfg.high   = wr_high_i;
`ifdef CLKGEN_PHASE_EN
    wr_cfg.phase  = wr_phase_i;
`endif
  end

  always_comb begin
    run_q   = en_q && (sh_q.period != '0);
    at_wrap = run_q && (cnt_q >= sh_q.period - cnt_t'(1));
    // A zero period never wraps, so staged values must be taken at once.
    apply   = pend_q && (!enable_i || (sh_q.period == '0) || at_wrap);

    sh_d   = sh_q;
    st_d   = st_q;
    pend_d = pend_q;

    if (!enable_i || (sh_q.period == '0) || at_wrap) begin
      cnt_d = '0;
    end else if (!en_q) begin
`ifdef CLKGEN_PHASE_EN
      cnt_d = start_cnt(sh_q);
`else
      cnt_d = '0;
`endif
    end else begin
      cnt_d = cnt_q + cnt_t'(1);
    end

    if (apply) begin
      sh_d   = st_q;
      pend_d = 1'b0;
    end
    if (wr_en_i) begin
      st_d   = wr_cfg;
      pend_d = 1'b1;
    end

    // Outputs are computed from next-state values so they stay aligned with cnt.
    clk_d  = enable_i && (sh_d.period != '0) && (cnt_d < sh_d.high);
    tick_d = enable_i && (sh_d.period != '0) && (cnt_d == sh_d.period - cnt_t'(1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_q   <= '0;
      st_q   <= '0;
      pend_q <= 1'b0;
      cnt_q  <= '0;
      en_q   <= 1'b0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      st_q   <= st_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      en_q   <= enable_i;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign pending_o     = pend_q;
  assign clk_out_o     = clk_q;
  assign period_tick_o = tick_q;

endmodule

// File: rtl/clkgen_multi.sv
// Multi-channel programmable clock/PWM generator: config write decode plus NUM_CH channels.
// CLKGEN_PHASE_EN adds the cfg_phase input; counter width comes from clkgen_pkg::CNT_W.
module clkgen_multi
  import clkgen_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] enable,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [CNT_W-1:0]  cfg_high,
`ifdef CLKGEN_PHASE_EN
  input  logic [CNT_W-1:0]  cfg_phase,
`endif
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] period_tick
);

  // Handshake: a write transfers on any edge where cfg_valid && cfg_ready.
  // cfg_ready is low only while the addressed channel still holds an unapplied
  // staged config; writes to nonexistent channels are accepted and dropped.
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] wr_en;

  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) begin
        cfg_ready = !pending[i];
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign wr_en[i] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));

    clkgen_channel u_ch (
      .clk           (clk),
      .rst_n         (rst_n),
      .enable_i      (enable[i]),
      .wr_en_i       (wr_en[i]),
      .wr_period_i   (cfg_period),
      .wr_high_i     (cfg_high),
`ifdef CLKGEN_PHASE_EN
      .wr_phase_i    (cfg_phase),
`endif
      .pending_o     (pending[i]),
      .clk_out_o     (clk_out[i]),
      .period_tick_o (period_tick[i])
    );
  end

endmodule

// File: tb/tb_clkgen_multi.sv
// Directed bench for clkgen_multi: per-cycle expected outputs queued ahead, popped at negedge.
// CLKGEN_PHASE_EN enables the phase-offset steps.
module tb_clkgen_multi;
  localparam int NUM_CH = 5;
  localparam int CH_W   = 3;
  localparam int CNT_W  = clkgen_pkg::CNT_W;
  localparam int EW     = 2 * NUM_CH;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NUM_CH-1:0] enable;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_period;
  logic [CNT_W-1:0]  cfg_high;
`ifdef CLKGEN_PHASE_EN
  logic [CNT_W-1:0]  cfg_phase;
`endif
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] period_tick;

  int            errors = 0;
  int            checks = 0;
  string         tag = "reset";
  logic [EW-1:0] exp_q[$];

  always #5 clk = ~clk;

  clkgen_multi #(.NUM_CH(NUM_CH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_ch      (cfg_ch),
    .cfg_period  (cfg_period),
    .cfg_high    (cfg_high),
`ifdef CLKGEN_PHASE_EN
    .cfg_phase   (cfg_phase),
`endif
    .clk_out     (clk_out),
    .period_tick (period_tick)
  );

  task automatic push_exp(input logic [NUM_CH-1:0] c, input logic [NUM_CH-1:0] t);
    exp_q.push_back({c, t});
  endtask

  task automatic push_zero(input int n);
    for (int i = 0; i < n; i++) push_exp('0, '0);
  endtask

  task automatic run(input int n);
    logic [EW-1:0] e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $error("FAIL %s: scoreboard empty, clk_out=%b tick=%b", tag, clk_out, period_tick);
      end else begin
        e = exp_q.pop_front();
        assert (clk_out === e[EW-1:NUM_CH]) else begin
          errors++;
          $error("FAIL %s clk_out: got %b expected %b", tag, clk_out, e[EW-1:NUM_CH]);
        end
        checks++;
        assert (period_tick === e[NUM_CH-1:0]) else begin
          errors++;
          $error("FAIL %s period_tick: got %b expected %b", tag, period_tick, e[NUM_CH-1:0]);
        end
      end
    end
  endtask

  task automatic check_ready(input string name, input logic exp);
    #1;
    checks++;
    assert (cfg_ready === exp) else begin
      errors++;
      $error("FAIL %s cfg_ready: got %b expected %b", name, cfg_ready, exp);
    end
  endtask

  task automatic drive_cfg(input int ch, input int per, input int hi
`ifdef CLKGEN_PHASE_EN
                           , input int ph = 0
`endif
                          );
    cfg_valid  = 1'b1;
    cfg_ch     = CH_W'(ch);
    cfg_period = CNT_W'(per);
    cfg_high   = CNT_W'(hi);
`ifdef CLKGEN_PHASE_EN
    cfg_phase  = CNT_W'(ph);
`endif
  endtask

  // One-cycle write attempt; the caller has queued the expectation for that cycle.
  task automatic write_cfg(input int ch, input int per, input int hi, input logic exp_rdy);
    drive_cfg(ch, per, hi);
    check_ready($sformatf("%s_wr_ch%0d", tag, ch), exp_rdy);
    run(1);
    cfg_valid = 1'b0;
  endtask

  initial begin
    logic [NUM_CH-1:0] c, t;
    int                m;
    rst_n      = 1'b0;
    enable     = '0;
    cfg_valid  = 1'b0;
    cfg_ch     = '0;
    cfg_period = '0;
    cfg_high   = '0;
`ifdef CLKGEN_PHASE_EN
    cfg_phase  = '0;
`endif

    tag = "reset";
    push_zero(2);
    run(2);
    check_ready("reset_ready", 1'b1);
    rst_n = 1'b1;

    // ch0 period 4 high 1, ch1 period 2 high 1, run together
    tag = "cfg01";
    push_zero(3);
    write_cfg(0, 4, 1, 1'b1);
    write_cfg(1, 2, 1, 1'b1);
    run(1);
    enable = 5'b00011;
    tag = "ch0_ch1";
    for (int k = 0; k < 12; k++) begin
      c = '0; t = '0;
      c[0] = (k % 4) < 1;  t[0] = (k % 4) == 3;
      c[1] = (k % 2) == 0; t[1] = (k % 2) == 1;
      push_exp(c, t);
    end
    run(12);
    enable = '0;
    tag = "disable01";
    push_zero(1);
    run(1);

    // nonexistent channel: accepted, no effect
    tag = "oor";
    push_zero(2);
    write_cfg(6, 3, 3, 1'b1);
    cfg_ch = 3'd4;
    check_ready("oor_ch4_ready", 1'b1);
    run(1);

    // ch2 reconfigured mid-period, plus refused writes while pending
    tag = "cfg2";
    push_zero(2);
    write_cfg(2, 8, 4, 1'b1);
    run(1);
    enable = 5'b00100;
    tag = "ch2_reconf";
    for (int k = 0; k < 20; k++) begin
      c = '0; t = '0;
      if (k < 8) begin
        c[2] = k < 4; t[2] = k == 7;
      end else if (k < 12) begin
        m = k - 8;  c[2] = m < 2; t[2] = m == 3;
      end else begin
        m = (k - 12) % 6; c[2] = m < 3; t[2] = m == 5;
      end
      push_exp(c, t);
    end
    run(4);
    write_cfg(2, 4, 2, 1'b1);
    write_cfg(2, 3, 1, 1'b0);
    run(2);
    drive_cfg(2, 6, 3);
    check_ready("apply_cycle_refused", 1'b0);
    run(1);
    check_ready("after_apply_accept", 1'b1);
    run(1);
    cfg_valid = 1'b0;
    run(10);
    enable = '0;
    tag = "disable2";
    push_zero(1);
    run(1);

    // ch3: 100% duty, then period 0, then immediate apply out of period 0
    tag = "cfg3";
    push_zero(2);
    write_cfg(3, 5, 5, 1'b1);
    run(1);
    enable = 5'b01000;
    tag = "ch3_bounds";
    for (int k = 0; k < 23; k++) begin
      c = '0; t = '0;
      if (k < 15) begin
        c[3] = 1'b1; t[3] = (k % 5) == 4;
      end else if (k >= 19) begin
        m = (k - 19) % 2; c[3] = m == 0; t[3] = m == 1;
      end
      push_exp(c, t);
    end
    run(12);
    write_cfg(3, 0, 3, 1'b1);
    run(5);
    write_cfg(3, 2, 1, 1'b1);
    run(4);

    // reset mid-operation with ch3 still enabled: config lost
    tag = "mid_reset";
    rst_n = 1'b0;
    push_zero(1);
    run(1);
    rst_n = 1'b1;
    check_ready("post_reset_ready", 1'b1);
    push_zero(4);
    run(3);
    write_cfg(3, 3, 2, 1'b1);
    tag = "post_reset_run";
    for (int k = 0; k < 6; k++) begin
      c = '0; t = '0;
      c[3] = (k % 3) < 2; t[3] = (k % 3) == 2;
      push_exp(c, t);
    end
    run(6);
    enable = '0;
    push_zero(1);
    run(1);

`ifdef CLKGEN_PHASE_EN
    tag = "phase2";
    push_zero(2);
    drive_cfg(0, 4, 2, 2);
    check_ready("phase2_wr", 1'b1);
    run(1);
    cfg_valid = 1'b0;
    run(1);
    enable = 5'b00001;
    for (int k = 0; k < 8; k++) begin
      c = '0; t = '0;
      m = (2 + k) % 4; c[0] = m < 2; t[0] = m == 3;
      push_exp(c, t);
    end
    run(8);
    enable = '0;
    push_zero(1);
    run(1);

    tag = "phase9";
    push_zero(2);
    drive_cfg(0, 4, 2, 9);
    check_ready("phase9_wr", 1'b1);
    run(1);
    cfg_valid = 1'b0;
    run(1);
    enable = 5'b00001;
    for (int k = 0; k < 8; k++) begin
      c = '0; t = '0;
      m = (3 + k) % 4; c[0] = m < 2; t[0] = m == 3;
      push_exp(c, t);
    end
    run(8);
    enable = '0;
    push_zero(1);
    run(1);
`endif

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
